io_config_chain: RTL and testbench

IO_CONFIG_CHAIN -- requirements
Module: io_config_chain

---
 rtl/io_config_chain.sv | 147 ++++++++++++++
 tb/tb_io_config_chain.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/io_config_chain.sv
// Serial IO configuration chain: shifts CHAIN_LEN bits into a shadow register,
// checks even parity and commits to per-group select registers, then passes the token on.

module io_cfg_group #(
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit,
   input  logic [SEL_W-1:0] sel_d,
   output logic [SEL_W-1:0] sel_q
);

   always_ff @(posedge clk) begin
      if (!reset)
         sel_q <= '0;
      else if (commit)
         sel_q <= sel_d;
   end

endmodule

module io_config_chain #(
   parameter int N_IO  = 8,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  prgm_b,
   input  logic                  io_prgm_b,
   input  logic                  io_prgm_b_in,
   input  logic                  bit_in,
   output logic                  io_prgm_b_out,
   output logic                  bit_out,
   output logic [N_IO*SEL_W-1:0] cfg_out,
   output logic                  cfg_err
);

   localparam int CHAIN_LEN = N_IO * SEL_W;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN);

   typedef enum logic [2:0] {IDLE, SHIFT, PARITY, DONE, ERROR} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     count, cnt_nxt;
   logic [CHAIN_LEN-1:0] shadow;
   logic [CHAIN_LEN:0]   shift_word;
   logic                 shift_en, parity_ok, last_bit;
   logic                 data_shift, commit, set_err, clr_err, done_hold;

   assign shift_en   = !prgm_b && io_prgm_b && io_prgm_b_in;
   assign parity_ok  = ~(^shadow ^ bit_in);
   assign shift_word = {bit_in, shadow};
   // IDLE captures bit 1; SHIFT never runs with count already at CHAIN_LEN
   assign cnt_nxt    = (state == IDLE) ? CNT_W'(1) : count + 1'b1;
   assign last_bit   = (cnt_nxt == LAST);

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (shift_en)
               state_nxt = last_bit ? PARITY : SHIFT;
         SHIFT:
            if (prgm_b)
               state_nxt = IDLE;
            else if (shift_en && last_bit)
               state_nxt = PARITY;
         PARITY:
            if (prgm_b)
               state_nxt = IDLE;
            else if (shift_en)
               state_nxt = parity_ok ? DONE : ERROR;
         DONE, ERROR:
            if (prgm_b)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      data_shift = 1'b0;
      commit     = 1'b0;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      done_hold  = 1'b0;
      case (state)
         IDLE: begin
            data_shift = shift_en;
            clr_err    = shift_en;
         end
         SHIFT:
            data_shift = shift_en;
         PARITY: begin
            commit  = shift_en && parity_ok;
            set_err = shift_en && !parity_ok;
         end
         DONE:
            done_hold = !prgm_b;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count         <= '0;
         shadow        <= '0;
         bit_out       <= 1'b0;
         cfg_err       <= 1'b0;
         io_prgm_b_out <= 1'b0;
      end else begin
         if (data_shift) begin
            shadow  <= shift_word[CHAIN_LEN:1];
            count   <= cnt_nxt;
            bit_out <= shadow[0];
         end else if (state_nxt == IDLE) begin
            count <= '0;
         end
         if (clr_err)
            cfg_err <= 1'b0;
         else if (set_err)
            cfg_err <= 1'b1;
         // token rises the cycle after the commit edge and drops when prgm_b returns
         io_prgm_b_out <= done_hold;
      end
   end

   for (genvar g = 0; g < N_IO; g++) begin : g_grp
      io_cfg_group #(.SEL_W(SEL_W)) u_grp (
         .clk    (clk),
         .reset  (reset),
         .commit (commit),
         .sel_d  (shadow[g*SEL_W +: SEL_W]),
         .sel_q  (cfg_out[g*SEL_W +: SEL_W])
      );
   end

endmodule

// File: tb/tb_io_config_chain.sv
// Directed bench for io_config_chain (N_IO=8, SEL_W=2): load, parity fail,
// pause, abort, reset and reprogram sequences with hand-computed results.

module tb_io_config_chain;

   localparam int N_IO  = 8;
   localparam int SEL_W = 2;
   localparam int CL    = N_IO * SEL_W;

   logic          clk = 1'b0;
   logic          reset, prgm_b, io_prgm_b, io_prgm_b_in, bit_in;
   logic          io_prgm_b_out, bit_out, cfg_err;
   logic [CL-1:0] cfg_out;
   logic [15:0]   d;
   int            n_chk = 0;
   int            n_pass = 0;

   io_config_chain #(.N_IO(N_IO), .SEL_W(SEL_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .prgm_b        (prgm_b),
      .io_prgm_b     (io_prgm_b),
      .io_prgm_b_in  (io_prgm_b_in),
      .bit_in        (bit_in),
      .io_prgm_b_out (io_prgm_b_out),
      .bit_out       (bit_out),
      .cfg_out       (cfg_out),
      .cfg_err       (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      prgm_b = 1'b0;
      bit_in = b;
      tick();
   endtask

   task automatic send_range(input logic [15:0] v, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         send_bit(v[i]);
   endtask

   task automatic release_prgm();
      prgm_b = 1'b1;
      bit_in = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b0; prgm_b = 1'b1; io_prgm_b = 1'b1; io_prgm_b_in = 1'b1; bit_in = 1'b0;
      tick(); tick();
      chk("rst_cfg_out", 32'(cfg_out), 32'h0);
      chk("rst_tok_out", 32'(io_prgm_b_out), 32'h0);
      chk("rst_bit_out", 32'(bit_out), 32'h0);
      chk("rst_cfg_err", 32'(cfg_err), 32'h0);
      reset = 1'b1;
      tick();

      // clean load: 0x0123 has four set bits, so the even-parity bit is 0
      d = 16'h0123;
      send_range(d, 0, 15);
      chk("clean_pre_commit", 32'(cfg_out), 32'h0);
      send_bit(1'b0);
      chk("clean_cfg_out", 32'(cfg_out), 32'h0123);
      chk("clean_tok_same_edge", 32'(io_prgm_b_out), 32'h0);
      chk("clean_cfg_err", 32'(cfg_err), 32'h0);
      send_bit(1'b1);
      chk("clean_tok_next", 32'(io_prgm_b_out), 32'h1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      chk("done_ignores_shift", 32'(cfg_out), 32'h0123);
      chk("done_tok_holds", 32'(io_prgm_b_out), 32'h1);

      // abort after 11 bits, then a full 0xFFFF load
      release_prgm();
      chk("ret_idle_tok", 32'(io_prgm_b_out), 32'h0);
      d = 16'h5A5A;
      send_range(d, 0, 10);
      release_prgm();
      chk("abort_cfg_out", 32'(cfg_out), 32'h0123);
      chk("abort_tok", 32'(io_prgm_b_out), 32'h0);
      d = 16'hFFFF;
      send_range(d, 0, 15);
      chk("ffff_pre_commit", 32'(cfg_out), 32'h0123);
      send_bit(1'b0);
      chk("ffff_cfg_out", 32'(cfg_out), 32'hFFFF);
      tick();
      chk("ffff_tok", 32'(io_prgm_b_out), 32'h1);

      // parity fail: 0x3C3C has eight set bits, so parity 1 is wrong
      release_prgm();
      d = 16'h3C3C;
      send_range(d, 0, 15);
      send_bit(1'b1);
      chk("perr_cfg_out", 32'(cfg_out), 32'hFFFF);
      chk("perr_cfg_err", 32'(cfg_err), 32'h1);
      chk("perr_tok", 32'(io_prgm_b_out), 32'h0);
      send_bit(1'b0);
      chk("perr_tok_later", 32'(io_prgm_b_out), 32'h0);
      chk("perr_err_holds", 32'(cfg_err), 32'h1);
      release_prgm();
      chk("perr_err_in_idle", 32'(cfg_err), 32'h1);

      // pause three cycles after the eighth bit; garbage on bit_in must be ignored
      d = 16'h0123;
      send_bit(d[0]);
      chk("shift_entry_clr_err", 32'(cfg_err), 32'h0);
      send_range(d, 1, 7);
      io_prgm_b_in = 1'b0;
      bit_in = 1'b1; tick();
      bit_in = 1'b0; tick();
      bit_in = 1'b1; tick();
      io_prgm_b_in = 1'b1;
      send_range(d, 8, 15);
      chk("pause_pre_commit", 32'(cfg_out), 32'hFFFF);
      send_bit(1'b0);
      chk("pause_cfg_out", 32'(cfg_out), 32'h0123);
      tick();
      chk("pause_tok", 32'(io_prgm_b_out), 32'h1);

      // reprogram: one-cycle prgm_b pulse, then 0xA5A5 (eight set bits, parity 0)
      release_prgm();
      chk("reprog_tok_falls", 32'(io_prgm_b_out), 32'h0);
      d = 16'hA5A5;
      send_range(d, 0, 15);
      send_bit(1'b0);
      chk("reprog_cfg_out", 32'(cfg_out), 32'hA5A5);
      chk("reprog_cfg_err", 32'(cfg_err), 32'h0);
      tick();
      chk("reprog_tok_rises", 32'(io_prgm_b_out), 32'h1);

      // reset mid-shift at bit 5, then reload 0x1234 (five set bits, parity 1)
      release_prgm();
      d = 16'h1234;
      send_range(d, 0, 4);
      reset = 1'b0;
      tick();
      chk("midrst_cfg_out", 32'(cfg_out), 32'h0);
      chk("midrst_tok", 32'(io_prgm_b_out), 32'h0);
      chk("midrst_bit_out", 32'(bit_out), 32'h0);
      chk("midrst_cfg_err", 32'(cfg_err), 32'h0);
      reset = 1'b1;
      release_prgm();
      send_range(d, 0, 15);
      send_bit(1'b1);
      chk("reload_cfg_out", 32'(cfg_out), 32'h1234);
      tick();
      chk("reload_tok", 32'(io_prgm_b_out), 32'h1);

      // reset wins while in DONE
      reset = 1'b0;
      tick();
      chk("done_rst_cfg_out", 32'(cfg_out), 32'h0);
      chk("done_rst_tok", 32'(io_prgm_b_out), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
